// File: rtl/spi_rx_capture.sv
// SPI receive capture: byte-complete edge detect, RX FIFO and device-bus register window.
// Optional SPI_RX_DROP_COUNT_EN adds a saturating drop counter readable at 0x1C.
module spi_rx_capture #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int RegAddr   = 12,
  parameter int Depth     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [DataWidth-1:0] device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [DataWidth-1:0] device_rdata_o,
  input  logic [7:0]           byte_data_i,
  input  logic                 byte_done_i,
  output logic                 irq_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  localparam logic [RegAddr-1:0] OffRxData = RegAddr'(16'h10);
  localparam logic [RegAddr-1:0] OffStatus = RegAddr'(16'h14);
  localparam logic [RegAddr-1:0] OffCtrl   = RegAddr'(16'h18);
  localparam logic [RegAddr-1:0] OffDrop   = RegAddr'(16'h1C);

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    ptr_next = (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [7:0]           mem [Depth];
  logic [PtrW-1:0]      wr_ptr, rd_ptr;
  logic [CntW-1:0]      count;
  logic                 byte_done_q;
  logic                 ovf, irq_en;
  logic                 full, empty;
  logic [RegAddr-1:0]   addr_lo;
  logic                 push_req, push_ok, pop, ovf_evt;
  logic                 rd_en, ctrl_wr, clear, clr_ovf;
  logic [31:0]          rd_word;
  logic                 vld_p1;
  logic [DataWidth-1:0] rdata_p1;
  logic [15:0]          drop_cnt;
  logic                 unused_bits;

  assign unused_bits = ^{device_addr_i[AddrWidth-1:RegAddr], device_wdata_i[DataWidth-1:3],
                         device_be_i[3:1]};

  assign addr_lo = device_addr_i[RegAddr-1:0];
  assign empty   = (count == '0);
  assign full    = (count == CntW'(Depth));

  assign push_req = byte_done_i & ~byte_done_q;
  assign rd_en    = device_req_i & ~device_we_i;
  assign ctrl_wr  = device_req_i & device_we_i & device_be_i[0] & (addr_lo == OffCtrl);
  assign clear    = ctrl_wr & device_wdata_i[0];
  assign clr_ovf  = ctrl_wr & device_wdata_i[1];
  assign pop      = rd_en & (addr_lo == OffRxData) & ~empty & ~clear;
  // A pop in the same cycle frees the slot the push needs, so full alone does not drop.
  assign push_ok  = push_req & ~clear & (~full | pop);
  assign ovf_evt  = push_req & ~clear & full & ~pop;

  always_comb begin
    rd_word = '0;
    case (addr_lo)
      OffRxData: rd_word = empty ? 32'd0 : {23'd0, 1'b1, mem[rd_ptr]};
      OffStatus: rd_word = {16'd0, 8'(count), 5'd0, ovf, empty, full};
      OffCtrl:   rd_word = {29'd0, irq_en, 2'b00};
`ifdef SPI_RX_DROP_COUNT_EN
      OffDrop:   rd_word = {16'd0, drop_cnt};
`endif
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= byte_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byte_done_q <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      irq_en      <= 1'b0;
    end else begin
      byte_done_q <= byte_done_i;
      if (ctrl_wr) irq_en <= device_wdata_i[2];
      if (clr_ovf)      ovf <= 1'b0;
      else if (ovf_evt) ovf <= 1'b1;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= ptr_next(wr_ptr);
        if (pop)     rd_ptr <= ptr_next(rd_ptr);
        if (push_ok && !pop)      count <= count + 1'b1;
        else if (pop && !push_ok) count <= count - 1'b1;
      end
    end
  end

`ifdef SPI_RX_DROP_COUNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_ovf) drop_cnt <= '0;
    else if (ovf_evt)     drop_cnt <= sat_inc16(drop_cnt);
  end
`else
  assign drop_cnt = '0;
`endif

  // Response stage: request cycle -> p1
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= device_req_i;
      rdata_p1 <= rd_en ? DataWidth'(rd_word) : '0;
    end
  end

  assign device_rvalid_o = vld_p1;
  assign device_rdata_o  = rdata_p1;
  assign irq_o           = irq_en & ~empty;

endmodule

// File: tb/tb_spi_rx_capture.sv
// Randomized + directed bench for spi_rx_capture against a queue-based register model.
module tb_spi_rx_capture;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic [7:0]  bdata = '0;
  logic        bd = 1'b0;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q[$];
  bit         m_ovf = 0;
  bit         m_irq_en = 0;
  int         m_drop = 0;
  bit         m_bd_prev = 0;

  spi_rx_capture #(.AddrWidth(32), .DataWidth(32), .RegAddr(12), .Depth(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .device_req_i(req), .device_addr_i(addr), .device_we_i(we),
    .device_be_i(be), .device_wdata_i(wdata), .device_rvalid_o(rvalid), .device_rdata_o(rdata),
    .byte_data_i(bdata), .byte_done_i(bd), .irq_o(irq));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] off);
    logic [31:0] v;
    v = 32'd0;
    case (off)
      12'h010: if (q.size() > 0) v = {23'd0, 1'b1, q[0]};
      12'h014: v = {16'd0, 8'(q.size()), 5'd0, m_ovf, q.size() == 0, q.size() == DEPTH};
      12'h018: v = {29'd0, m_irq_en, 2'b00};
`ifdef SPI_RX_DROP_COUNT_EN
      12'h01C: v = 32'(m_drop);
`endif
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // Apply current inputs for one clock, advance the model, compare outputs after the edge.
  task automatic step();
    logic [31:0] exp_rd;
    logic [11:0] off;
    bit exp_v, pe, rdreq, cw, clr, clro, evt;
    off = addr[11:0];
    exp_rd = 32'd0;
    exp_v = 0;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_irq_en = 0; m_drop = 0; m_bd_prev = 0;
    end else begin
      pe = bd && !m_bd_prev;
      m_bd_prev = bd;
      rdreq = req && !we;
      if (rdreq) exp_rd = model_read(off);
      cw   = req && we && be[0] && off == 12'h018;
      clr  = cw && wdata[0];
      clro = cw && wdata[1];
      evt  = 0;
      if (clr) q.delete();
      else begin
        if (rdreq && off == 12'h010 && q.size() > 0) void'(q.pop_front());
        if (pe) begin
          if (q.size() < DEPTH) q.push_back(bdata);
          else evt = 1;
        end
      end
      if (cw) m_irq_en = wdata[2];
      if (clro) begin
        m_ovf = 0; m_drop = 0;
      end else if (evt) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
      exp_v = req;
    end
    @(posedge clk);
    #1;
    chk("rvalid", 32'(rvalid), 32'(exp_v));
    chk("rdata", rdata, exp_rd);
    chk("irq", 32'(irq), 32'(m_irq_en && q.size() > 0));
  endtask

  task automatic rd(input logic [11:0] off, output logic [31:0] d);
    req = 1; we = 0; addr = $urandom; addr[11:0] = off;
    step();
    d = rdata;
    req = 0;
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] data);
    req = 1; we = 1; be = 4'hF; addr = $urandom; addr[11:0] = off; wdata = data;
    step();
    req = 0; we = 0;
  endtask

  task automatic push(input logic [7:0] b);
    bd = 1; bdata = b;
    step();
    bd = 0; bdata = $urandom;
    step();
  endtask

  logic [11:0] offs [6] = '{12'h010, 12'h010, 12'h014, 12'h018, 12'h01C, 12'h020};

  initial begin
    logic [31:0] d;
    rst = 1;
    step();
    step();
    rst = 0;

    // Two bytes in, two out, then empty
    push(8'hA5);
    push(8'h3C);
    rd(12'h010, d); chk("rx_a5", d, 32'h1A5);
    rd(12'h010, d); chk("rx_3c", d, 32'h13C);
    rd(12'h010, d); chk("rx_empty", d, 32'h000);
    rd(12'h014, d); chk("st_empty", 32'(d[1]), 32'd1);

    // Level held high: one push only
    bd = 1; bdata = 8'h55;
    repeat (10) step();
    bd = 0;
    step();
    rd(12'h014, d); chk("st_cnt1", 32'(d[15:8]), 32'd1);
    rd(12'h010, d); chk("rx_55", d, 32'h155);

    // Overflow with 18 pushes
    for (int i = 1; i <= 18; i++) push(8'(i));
    rd(12'h014, d); chk("st_full_ovf", d, 32'h1005);
    rd(12'h010, d); chk("rx_first", d, 32'h101);
`ifdef SPI_RX_DROP_COUNT_EN
    rd(12'h01C, d); chk("drop2", d, 32'd2);
`endif
    wr(12'h018, 32'h2);
    rd(12'h014, d); chk("st_ovf_clr", d, 32'h0F00);
`ifdef SPI_RX_DROP_COUNT_EN
    rd(12'h01C, d); chk("drop0", d, 32'd0);
`endif

    // Full FIFO: pop and push in the same cycle
    push(8'h77);
    req = 1; we = 0; addr = 32'h0000_0010; bd = 1; bdata = 8'h88;
    step();
    chk("rx_full_pop", rdata, 32'h102);
    req = 0; bd = 0;
    step();
    rd(12'h014, d); chk("st_full_keep", d, 32'h1001);

    // Interrupt enable and clear-vs-push
    wr(12'h018, 32'h1);
    wr(12'h018, 32'h4);
    chk("irq_empty", 32'(irq), 32'd0);
    bd = 1; bdata = 8'h11;
    step();
    chk("irq_rise", 32'(irq), 32'd1);
    bd = 0;
    step();
    req = 1; we = 1; be = 4'h1; addr = 32'h0000_0018; wdata = 32'h5; bd = 1; bdata = 8'h22;
    step();
    req = 0; we = 0; bd = 0;
    chk("irq_clr", 32'(irq), 32'd0);
    rd(12'h014, d); chk("st_clr_push", d, 32'h0002);

    // Reset with data queued and a read in flight
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    req = 1; we = 0; addr = 32'h0000_0010;
    step();
    rst = 1;
    step();
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 0; req = 0;
    rd(12'h014, d); chk("rst_cnt", 32'(d[15:8]), 32'd0);
    rd(12'h018, d); chk("rst_irqen", d, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      req = ($urandom_range(0, 2) == 0);
      we = ($urandom_range(0, 3) == 0);
      addr = $urandom;
      addr[11:0] = offs[$urandom_range(0, 5)];
      be = 4'($urandom);
      wdata = $urandom;
      wdata[0] = ($urandom_range(0, 15) == 0);
      wdata[1] = ($urandom_range(0, 3) == 0);
      if (c < 2000) bd = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 5) == 0) bd = ~bd;
      bdata = 8'($urandom);
      step();
    end
    rst = 0; req = 0; we = 0; bd = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
